// File: rtl/if_id_fifo.sv
// IF/ID instruction queue: DEPTH-entry circular buffer between fetch and decode.
// Empty head reads as a zero bubble, matching the legacy single-entry IF/ID register.
module if_id_fifo #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
    localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full     = (cnt == CntFull);
        empty    = (cnt == '0);
        if_ready = !full;
        id_valid = !empty;
        push     = if_valid && if_ready;
        pop      = id_valid && id_ready;
        count    = cnt;
        id_pc    = '0;
        id_inst  = '0;
        if (!empty) begin
            id_pc   = pc_mem[rd_ptr];
            id_inst = inst_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CntOne;
                2'b01:   cnt <= cnt - CntOne;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage has no reset; contents are only observed through rd_ptr when non-empty.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo: a queue-based scoreboard predicts head, count and handshakes.
module tb_if_id_fifo;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [PTR_W:0]    count;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] sb[$];
    logic [31:0] fill_inst[4];

    if_id_fifo #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .if_valid(if_valid),
        .if_pc   (if_pc),
        .if_inst (if_inst),
        .if_ready(if_ready),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc   (id_pc),
        .id_inst (id_inst),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the scoreboard, then advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl, input logic rs, input bit chk);
        bit can_push;
        rst      = rs;
        flush    = fl;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        #1;
        if (chk) begin
            check("count", 64'(count), 64'(sb.size()));
            check("id_valid", 64'(id_valid), 64'(sb.size() != 0));
            check("if_ready", 64'(if_ready), 64'(sb.size() < DEPTH));
            if (sb.size() != 0) begin
                check("id_pc", 64'(id_pc), 64'(sb[0][63:32]));
                check("id_inst", 64'(id_inst), 64'(sb[0][31:0]));
            end else begin
                check("id_pc_bubble", 64'(id_pc), 64'h0);
                check("id_inst_bubble", 64'(id_inst), 64'h0);
            end
        end
        if (rs || fl) begin
            sb.delete();
        end else begin
            can_push = v && (sb.size() < DEPTH);
            if (rdy && sb.size() != 0) void'(sb.pop_front());
            if (can_push) sb.push_back({pc, inst});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        fill_inst[0] = 32'h13;
        fill_inst[1] = 32'h93;
        fill_inst[2] = 32'h113;
        fill_inst[3] = 32'h193;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with if_valid high
        step(1'b1, 32'hdead, 32'hbeef, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hdead, 32'hbeef, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_count", 64'(count), 64'h0);
        check("reset_if_ready", 64'(if_ready), 64'h1);

        // Fill to DEPTH, then a rejected fifth push
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), fill_inst[i], 1'b0, 1'b0, 1'b0, 1'b1);
        check("fill_count", 64'(count), 64'h4);
        check("fill_if_ready", 64'(if_ready), 64'h0);
        step(1'b1, 32'h10, 32'h213, 1'b0, 1'b0, 1'b0, 1'b1);
        check("full_reject_count", 64'(count), 64'h4);

        // Drain in order, then observe the empty bubble
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Streaming push+pop; pointers wrap several times
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'(32'h100 + i * 4), 32'(32'h1000 + i), 1'b1, 1'b0, 1'b0, 1'b1);
        check("stream_count", 64'(count), 64'h1);

        // Refill to full, then pop with a rejected push, then the push goes in
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'(32'h180 + i * 4), 32'(32'h2000 + i), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h200, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("full_pop_count", 64'(count), 64'h3);
        step(1'b1, 32'h200, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("full_pop_accept_count", 64'(count), 64'h3);

        // Flush with concurrent push and pop
        step(1'b1, 32'h300, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("flush_id_valid", 64'(id_valid), 64'h0);

        // Mid-stream reset at count 2, then a fresh push
        step(1'b1, 32'h500, 32'h5000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h504, 32'h5001, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h400, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("post_reset_head", 64'(id_pc), 64'h400);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
